// File: rtl/vanilla_sb_clear_pkg.sv
// Shared types for the vanilla core scoreboard-clear scheduler.
package vanilla_sb_clear_pkg;

  // Which writeback source owns the RF write port in a given cycle.
  typedef enum logic [1:0] {
    e_src_none   = 2'd0,
    e_src_remote = 2'd1,
    e_src_idiv   = 2'd2
  } sb_clear_src_e;

  localparam int unsigned default_data_width_lp     = 32;
  localparam int unsigned default_reg_addr_width_lp = 5;

  // Remote response entry layout for the default configuration; the FIFO
  // stores the same {id, data} packing as a flat vector so that non-default
  // widths work too.
  typedef struct packed {
    logic [default_reg_addr_width_lp-1:0] id;
    logic [default_data_width_lp-1:0]     data;
  } remote_resp_s;

endpackage

// File: rtl/vanilla_sb_resp_fifo.sv
// Circular buffer for remote load responses. The producer cannot be stalled,
// so a write while full is dropped (and reported) unless a read frees the
// head slot in the same cycle.
module vanilla_sb_resp_fifo #(
  parameter int width_p = 37,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               dropped_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r;
  logic [ptr_w_lp-1:0] rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq_s;
  logic                deq_s;

  // Status flags and enqueue/dequeue qualification from the current count.
  always_comb begin
    full_o    = (count_r == els_lp);
    empty_o   = (count_r == cnt_w_lp'(0));
    deq_s     = yumi_i & ~empty_o;
    enq_s     = v_i & (~full_o | deq_s);
    dropped_o = v_i & full_o & ~deq_s;
    data_o    = mem_r[rptr_r];
  end

  // Entry storage; write slot equals the head slot only when a simultaneous
  // dequeue has already consumed it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem_r[i] <= '0;
      end
    end else if (enq_s) begin
      mem_r[wptr_r] <= data_i;
    end else begin
      mem_r[wptr_r] <= mem_r[wptr_r];
    end
  end

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_s) wptr_r <= wptr_r + ptr_w_lp'(1);
      else       wptr_r <= wptr_r;
      if (deq_s) rptr_r <= rptr_r + ptr_w_lp'(1);
      else       rptr_r <= rptr_r;
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vanilla_sb_clear_scheduler.sv
// Arbitrates the integer RF write port and scoreboard-clear channel between
// the pipeline writeback, buffered remote load responses and the idiv unit.
module vanilla_sb_clear_scheduler
  import vanilla_sb_clear_pkg::*;
#(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2,
  parameter int starve_limit_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        pipe_wb_v_i,
  input  logic                        remote_v_i,
  input  logic [reg_addr_width_p-1:0] remote_id_i,
  input  logic [data_width_p-1:0]     remote_data_i,
  output logic                        remote_fifo_full_o,
  input  logic                        idiv_v_i,
  input  logic [reg_addr_width_p-1:0] idiv_id_i,
  input  logic [data_width_p-1:0]     idiv_data_i,
  output logic                        idiv_yumi_o,
  output logic                        rf_w_v_o,
  output logic [reg_addr_width_p-1:0] rf_w_addr_o,
  output logic [data_width_p-1:0]     rf_w_data_o,
  output logic                        sb_clear_o,
  output logic [reg_addr_width_p-1:0] sb_clear_id_o,
  output logic                        overflow_o
);

  localparam int entry_w_lp  = reg_addr_width_p + data_width_p;
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  logic [entry_w_lp-1:0]       fifo_head_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic                        fifo_dropped_s;
  sb_clear_src_e               grant_src_s;
  logic [reg_addr_width_p-1:0] win_id_s;
  logic [data_width_p-1:0]     win_data_s;
  logic                        granted_s;
  logic [starve_w_lp-1:0]      starve_r;
  logic                        overflow_r;

  vanilla_sb_resp_fifo #(
    .width_p (entry_w_lp),
    .els_p   (fifo_els_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .v_i       (remote_v_i),
    .data_i    ({remote_id_i, remote_data_i}),
    .yumi_i    (grant_src_s == e_src_remote),
    .data_o    (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .dropped_o (fifo_dropped_s)
  );

  // Pick the port owner: pipeline blocks everyone, remote beats idiv until
  // idiv has lost starve_limit_p contended cycles in a row.
  always_comb begin
    grant_src_s = e_src_none;
    if (reset_i || pipe_wb_v_i) begin
      grant_src_s = e_src_none;
    end else if (!fifo_empty_s && idiv_v_i) begin
      grant_src_s = (starve_r == starve_max_lp) ? e_src_idiv : e_src_remote;
    end else if (!fifo_empty_s) begin
      grant_src_s = e_src_remote;
    end else if (idiv_v_i) begin
      grant_src_s = e_src_idiv;
    end else begin
      grant_src_s = e_src_none;
    end
  end

  // Route the winner onto the write port; x0 still clears but never writes.
  always_comb begin
    win_id_s   = '0;
    win_data_s = '0;
    case (grant_src_s)
      e_src_remote: {win_id_s, win_data_s} = fifo_head_s;
      e_src_idiv: begin
        win_id_s   = idiv_id_i;
        win_data_s = idiv_data_i;
      end
      default: begin
        win_id_s   = '0;
        win_data_s = '0;
      end
    endcase
    granted_s          = (grant_src_s != e_src_none);
    rf_w_v_o           = granted_s & (win_id_s != '0);
    rf_w_addr_o        = win_id_s;
    rf_w_data_o        = win_data_s;
    sb_clear_o         = granted_s;
    sb_clear_id_o      = win_id_s;
    idiv_yumi_o        = (grant_src_s == e_src_idiv);
    remote_fifo_full_o = fifo_full_s & ~reset_i;
    overflow_o         = overflow_r;
  end

  // Count consecutive contended cycles that idiv lost to remote.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_r <= '0;
    end else if (pipe_wb_v_i) begin
      starve_r <= starve_r;
    end else if (!idiv_v_i || (grant_src_s == e_src_idiv)) begin
      starve_r <= '0;
    end else if ((grant_src_s == e_src_remote) && (starve_r != starve_max_lp)) begin
      starve_r <= starve_r + starve_w_lp'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Sticky flag once a remote response has been lost.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_r <= 1'b0;
    end else if (fifo_dropped_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_vanilla_sb_clear_scheduler.sv
// Directed table-driven bench for vanilla_sb_clear_scheduler (default params).
module tb_vanilla_sb_clear_scheduler;
  import vanilla_sb_clear_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        pipe_wb_v_i;
  logic        remote_v_i;
  logic [4:0]  remote_id_i;
  logic [31:0] remote_data_i;
  logic        remote_fifo_full_o;
  logic        idiv_v_i;
  logic [4:0]  idiv_id_i;
  logic [31:0] idiv_data_i;
  logic        idiv_yumi_o;
  logic        rf_w_v_o;
  logic [4:0]  rf_w_addr_o;
  logic [31:0] rf_w_data_o;
  logic        sb_clear_o;
  logic [4:0]  sb_clear_id_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  vanilla_sb_clear_scheduler #(
    .data_width_p(32), .reg_addr_width_p(5), .fifo_els_p(2), .starve_limit_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pipe_wb_v_i(pipe_wb_v_i),
    .remote_v_i(remote_v_i), .remote_id_i(remote_id_i), .remote_data_i(remote_data_i),
    .remote_fifo_full_o(remote_fifo_full_o),
    .idiv_v_i(idiv_v_i), .idiv_id_i(idiv_id_i), .idiv_data_i(idiv_data_i),
    .idiv_yumi_o(idiv_yumi_o), .rf_w_v_o(rf_w_v_o), .rf_w_addr_o(rf_w_addr_o),
    .rf_w_data_o(rf_w_data_o), .sb_clear_o(sb_clear_o), .sb_clear_id_o(sb_clear_id_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic pipe; logic rv; logic [4:0] rid; logic [31:0] rdata;
    logic iv; logic [4:0] iid; logic [31:0] idata;
    logic wv; logic [4:0] addr; logic [31:0] data;
    logic clr; logic [4:0] cid; logic yumi; logic full; logic ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int pipe, int rv, int rid, int rdata, int iv, int iid, int idata,
                              int wv, int addr, int data, int clr, int cid, int yumi,
                              int full, int ovf);
    vec_t v;
    v.pipe = pipe[0]; v.rv = rv[0]; v.rid = rid[4:0]; v.rdata = rdata;
    v.iv = iv[0]; v.iid = iid[4:0]; v.idata = idata;
    v.wv = wv[0]; v.addr = addr[4:0]; v.data = data;
    v.clr = clr[0]; v.cid = cid[4:0]; v.yumi = yumi[0]; v.full = full[0]; v.ovf = ovf[0];
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_rf_w_v"}, -1, {31'd0, rf_w_v_o}, 32'd0);
    chk({tag, "_sb_clear"}, -1, {31'd0, sb_clear_o}, 32'd0);
    chk({tag, "_yumi"}, -1, {31'd0, idiv_yumi_o}, 32'd0);
    chk({tag, "_full"}, -1, {31'd0, remote_fifo_full_o}, 32'd0);
    chk({tag, "_ovf"}, -1, {31'd0, overflow_o}, 32'd0);
    chk({tag, "_addr"}, -1, {27'd0, rf_w_addr_o}, 32'd0);
    chk({tag, "_data"}, -1, rf_w_data_o, 32'd0);
    chk({tag, "_cid"}, -1, {27'd0, sb_clear_id_o}, 32'd0);
  endtask

  initial begin
    // pipe rv rid rdata          iv iid idata | wv addr data           clr cid yumi full ovf
    // remote only, single response
    vecs.push_back(mk(0,1, 7,32'hDEADBEEF, 0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       1,7,32'hDEADBEEF,1,7,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       0,0,0,0,0,0,0,0));
    // full FIFO with simultaneous enqueue/dequeue across pointer wrap
    vecs.push_back(mk(1,1,10,32'hA0A,      0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,11,32'hB0B,      0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,12,32'hC0C,      0,0,0,       1,10,32'hA0A,1,10,0,1,0));
    vecs.push_back(mk(0,1,13,32'hD0D,      0,0,0,       1,11,32'hB0B,1,11,0,1,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       1,12,32'hC0C,1,12,0,1,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       1,13,32'hD0D,1,13,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       0,0,0,0,0,0,0,0));
    // x0 destinations, idiv alone, idiv blocked by pipe
    vecs.push_back(mk(0,1, 0,32'h1234,     0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       0,0,0,1,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            1,0,32'h99,  0,0,0,1,0,1,0,0));
    vecs.push_back(mk(0,0, 0,0,            1,20,32'h2020, 1,20,32'h2020,1,20,1,0,0));
    vecs.push_back(mk(1,0, 0,0,            1,20,32'h2020, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       0,0,0,0,0,0,0,0));
    // starvation: remote wins 4 contended cycles, idiv the 5th
    vecs.push_back(mk(0,1,21,32'h2101,     0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,22,32'h2202,     1,9,32'h9999, 1,21,32'h2101,1,21,0,0,0));
    vecs.push_back(mk(0,1,23,32'h2303,     1,9,32'h9999, 1,22,32'h2202,1,22,0,0,0));
    vecs.push_back(mk(0,1,24,32'h2404,     1,9,32'h9999, 1,23,32'h2303,1,23,0,0,0));
    vecs.push_back(mk(0,1,25,32'h2505,     1,9,32'h9999, 1,24,32'h2404,1,24,0,0,0));
    vecs.push_back(mk(0,1,26,32'h2606,     1,9,32'h9999, 1,9,32'h9999,1,9,1,0,0));
    // counter cleared: remote wins again first
    vecs.push_back(mk(0,0, 0,0,            1,8,32'h8888, 1,25,32'h2505,1,25,0,1,0));
    vecs.push_back(mk(0,0, 0,0,            1,8,32'h8888, 1,26,32'h2606,1,26,0,0,0));
    vecs.push_back(mk(0,0, 0,0,            1,8,32'h8888, 1,8,32'h8888,1,8,1,0,0));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       0,0,0,0,0,0,0,0));
    // pipe blocking, FIFO fills, third response dropped, sticky overflow
    vecs.push_back(mk(1,1, 3,32'h33,       0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1, 4,32'h44,       0,0,0,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1, 5,32'h55,       0,0,0,       0,0,0,0,0,0,1,0));
    vecs.push_back(mk(1,0, 0,0,            0,0,0,       0,0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       1,3,32'h33,1,3,0,1,1));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       1,4,32'h44,1,4,0,0,1));
    vecs.push_back(mk(0,0, 0,0,            0,0,0,       0,0,0,0,0,0,0,1));

    // reset with requests present: everything held at zero
    reset_i = 1'b1; pipe_wb_v_i = 1'b0;
    remote_v_i = 1'b1; remote_id_i = 5'd6; remote_data_i = 32'h66;
    idiv_v_i = 1'b1; idiv_id_i = 5'd5; idiv_data_i = 32'h55;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("in_reset");
    @(posedge clk_i); #1;
    reset_i = 1'b0; remote_v_i = 1'b0; idiv_v_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("post_reset_idle");

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      pipe_wb_v_i = vecs[i].pipe;
      remote_v_i = vecs[i].rv; remote_id_i = vecs[i].rid; remote_data_i = vecs[i].rdata;
      idiv_v_i = vecs[i].iv; idiv_id_i = vecs[i].iid; idiv_data_i = vecs[i].idata;
      @(negedge clk_i);
      chk("rf_w_v", i, {31'd0, rf_w_v_o}, {31'd0, vecs[i].wv});
      chk("sb_clear", i, {31'd0, sb_clear_o}, {31'd0, vecs[i].clr});
      chk("idiv_yumi", i, {31'd0, idiv_yumi_o}, {31'd0, vecs[i].yumi});
      chk("fifo_full", i, {31'd0, remote_fifo_full_o}, {31'd0, vecs[i].full});
      chk("overflow", i, {31'd0, overflow_o}, {31'd0, vecs[i].ovf});
      if (vecs[i].wv) begin
        chk("rf_w_addr", i, {27'd0, rf_w_addr_o}, {27'd0, vecs[i].addr});
        chk("rf_w_data", i, rf_w_data_o, vecs[i].data);
      end
      if (vecs[i].clr) begin
        chk("sb_clear_id", i, {27'd0, sb_clear_id_o}, {27'd0, vecs[i].cid});
      end
    end

    // mid-cycle reset: outputs drop without a clock edge, buffer discarded
    @(posedge clk_i); #1;
    pipe_wb_v_i = 1'b0; remote_v_i = 1'b1; remote_id_i = 5'd30; remote_data_i = 32'h3030;
    idiv_v_i = 1'b0;
    @(posedge clk_i); #1;
    remote_v_i = 1'b0; idiv_v_i = 1'b1; idiv_id_i = 5'd31; idiv_data_i = 32'h3131;
    #1;
    chk("pre_reset_rf_w_v", -1, {31'd0, rf_w_v_o}, 32'd1);
    chk("pre_reset_addr", -1, {27'd0, rf_w_addr_o}, 32'd30);
    chk("pre_reset_ovf", -1, {31'd0, overflow_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk_i); #1;
    reset_i = 1'b0; idiv_v_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("after_mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
